mem_w_encoder: RTL and testbench

//  Store-side counterpart of the load data decoder. Takes a store (SB/SH/SW)

---
 rtl/mem_w_encoder_pkg.sv | 47 ++++
 rtl/mem_w_encoder_align.sv | 22 ++
 rtl/mem_w_encoder.sv | 153 +++++++++++++++
 tb/tb_mem_w_encoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_w_encoder_pkg.sv
// Shared store-path definitions: fnc encodings, FSM state, beat record, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_w_encoder_pkg;

  // Store width encodings (same values the load decoder uses for LB/LH/LW).
  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // One word-aligned write beat toward memory.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } beat_t;

  // Byte-enable pattern of a store before it is shifted into its lanes.
  function automatic logic [3:0] base_mask(input logic [2:0] fnc);
    logic [3:0] m;
    case (fnc)
      FNC_SB:  m = 4'b0001;
      FNC_SH:  m = 4'b0011;
      FNC_SW:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Clears rs2 bits above the store width so lanes without an enable carry 0.
  function automatic logic [31:0] size_data(input logic [2:0] fnc, input logic [31:0] data);
    logic [31:0] d;
    case (fnc)
      FNC_SB:  d = {24'h0, data[7:0]};
      FNC_SH:  d = {16'h0, data[15:0]};
      FNC_SW:  d = data;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_w_encoder_align.sv
// Combinational lane aligner: fnc/offset/data -> 8-lane byte mask and 64-bit shifted data.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies the result with its own handshake.
import mem_w_encoder_pkg::*;

module store_lane_align (
  input  logic [2:0]  fnc,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic        fnc_ok
);

  // Shift the sized store into a two-word window; the upper half is the spill-over word.
  always_comb begin
    fnc_ok = (base_mask(fnc) != 4'b0000);
    mask8  = {4'b0000, base_mask(fnc)} << off;
    data64 = {32'h0, size_data(fnc, data)} << {off, 3'b000};
  end

endmodule

// File: rtl/mem_w_encoder.sv
// Store encoder: SB/SH/SW -> word-aligned write beats with byte enables; MEM_W_SPLIT_EN splits crossing stores.
// Latency: 1 cycle from request accept to mem_valid; one store per cycle while mem_ready is high.
// Backpressure: output beat held while mem_valid & ~mem_ready; req_ready low in SPLIT or when stalled.
import mem_w_encoder_pkg::*;

module mem_w_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fnc,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        busy,
  output logic        misalign_err
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        fnc_ok;
  logic        accept;
  logic        crossing;
  beat_t       beat0;
  beat_t       beat1;
  beat_t       out_q;

  store_lane_align u_align (
    .fnc    (req_fnc),
    .off    (req_addr[1:0]),
    .data   (req_data),
    .mask8  (mask8),
    .data64 (data64),
    .fnc_ok (fnc_ok)
  );

  // Request decode: handshake, word-crossing detect and both candidate beats.
  always_comb begin
    accept      = req_valid & req_ready;
    crossing    = fnc_ok & (mask8[7:4] != 4'b0000);
    beat0.addr  = {req_addr[31:2], 2'b00};
    beat0.wdata = data64[31:0];
    beat0.we    = mask8[3:0];
    // Adding 4 to the top word wraps to address 0 by 32-bit overflow.
    beat1.addr  = {req_addr[31:2], 2'b00} + 32'd4;
    beat1.wdata = data64[63:32];
    beat1.we    = mask8[7:4];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: only a crossing store in the split build leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef MEM_W_SPLIT_EN
        if (accept && crossing) begin
          state_nxt = ST_SPLIT;
        end
`endif
      end
      ST_SPLIT: begin
        if (mem_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request side ready only when idle and the output slot frees this cycle.
  always_comb begin
    req_ready = (state == ST_IDLE) & (~mem_valid | mem_ready);
    busy      = (state != ST_IDLE) | mem_valid;
  end

`ifdef MEM_W_SPLIT_EN
  beat_t pend_q;

  // Output beat register plus the pending second beat of a split store.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      out_q        <= '0;
      pend_q       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (state == ST_SPLIT) begin
        if (mem_ready) begin
          out_q <= pend_q;
        end
      end else if (accept) begin
        if (fnc_ok) begin
          out_q     <= beat0;
          mem_valid <= 1'b1;
          if (crossing) begin
            pend_q <= beat1;
          end
        end else begin
          mem_valid <= 1'b0;
        end
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{beat1.addr, beat1.wdata};

  // Output beat register; crossing stores are dropped and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      out_q        <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (accept) begin
        if (fnc_ok && !crossing) begin
          out_q     <= beat0;
          mem_valid <= 1'b1;
        end else begin
          mem_valid    <= 1'b0;
          misalign_err <= crossing;
        end
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end
`endif

  assign mem_addr  = out_q.addr;
  assign mem_wdata = out_q.wdata;
  assign mem_we    = out_q.we;

endmodule

// File: tb/tb_mem_w_encoder.sv
import mem_w_encoder_pkg::*;

module tb_mem_w_encoder;

`ifdef MEM_W_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fnc = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        busy;
  logic        misalign_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    err_cnt  = 0;
  int    exp_err  = 0;
  bit    rnd_en   = 1'b0;
  beat_t obs_q[$];
  int    cyc_q[$];
  beat_t exp_q[$];

  mem_w_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_fnc      (req_fnc),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .busy         (busy),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Beat/error monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
      obs_q.push_back('{addr: mem_addr, wdata: mem_wdata, we: mem_we});
      cyc_q.push_back(cyc);
    end
    if (misalign_err === 1'b1) err_cnt++;
  end

  // Random memory backpressure.
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Byte-by-byte reference: each byte lands at address addr+i, grouped per word.
  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int          sz;
    beat_t       b0;
    beat_t       b1;
    logic [31:0] ba;
    sz = (f == FNC_SB) ? 1 : (f == FNC_SH) ? 2 : (f == FNC_SW) ? 4 : 0;
    if (sz == 0) return;
    b0 = '{addr: a & ~32'd3, wdata: 32'h0, we: 4'h0};
    b1 = '{addr: 32'h0, wdata: 32'h0, we: 4'h0};
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      if ((ba & ~32'd3) == b0.addr) begin
        b0.wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
        b0.we[ba[1:0]] = 1'b1;
      end else begin
        b1.addr = ba & ~32'd3;
        b1.wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
        b1.we[ba[1:0]] = 1'b1;
      end
    end
    if (b1.we != 4'h0 && !SPLIT) begin
      exp_err++;
    end else begin
      exp_q.push_back(b0);
      if (b1.we != 4'h0) exp_q.push_back(b1);
    end
  endtask

  // Present one request and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_fnc   = f;
    req_addr  = a;
    req_data  = d;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept req_ready=%b want 1 addr=%h", req_ready, a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    cyc_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_valid, mem_addr, mem_wdata, mem_we, misalign_err, busy} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b a=%h d=%h we=%b e=%b busy=%b want all 0",
               mem_valid, mem_addr, mem_wdata, mem_we, misalign_err, busy);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_obs();
    mem_ready = 1'b1;
    send(FNC_SW, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if ({mem_valid, mem_addr, mem_wdata, mem_we} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'b1111}) begin
      n_fail++;
      $display("FAIL sw_latency got v=%b a=%h d=%h we=%b want 1/100/deadbeef/1111",
               mem_valid, mem_addr, mem_wdata, mem_we);
    end
    @(posedge clk);
    #1;
    send(FNC_SB, 32'h203, 32'h000000A5);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[1] !== '{addr: 32'h200, wdata: 32'hA5000000, we: 4'b1000}) begin
        n_fail++;
        $display("FAIL sb_beat got %h/%h/%b want 200/a5000000/1000",
                 obs_q[1].addr, obs_q[1].wdata, obs_q[1].we);
      end
    end
  endtask

  task automatic test_stall();
    clear_obs();
    mem_ready = 1'b0;
    send(FNC_SH, 32'h302, 32'h00001234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wdata, mem_we, req_ready} !==
          {1'b1, 32'h300, 32'h12340000, 4'b1100, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d got v=%b a=%h d=%h we=%b rdy=%b want 1/300/12340000/1100/0",
                 i, mem_valid, mem_addr, mem_wdata, mem_we, req_ready);
      end
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== '{addr: 32'h300, wdata: 32'h12340000, we: 4'b1100}) begin
      n_fail++;
      $display("FAIL stall_release got %0d beats want 1 beat 300/12340000/1100", obs_q.size());
    end
  endtask

  task automatic test_cross();
    clear_obs();
    mem_ready = 1'b1;
    send(FNC_SW, 32'h402, 32'hAABBCCDD);
    @(negedge clk);
    if (SPLIT) begin
      n_checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL split_hold got rdy=%b busy=%b want 0/1", req_ready, busy);
      end
    end else begin
      n_checks++;
      if (misalign_err !== 1'b1 || mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_pulse got err=%b v=%b want 1/0", misalign_err, mem_valid);
      end
      @(negedge clk);
      n_checks++;
      if (misalign_err !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_width got %b want 0", misalign_err);
      end
    end
    @(posedge clk);
    #1;
    send(FNC_SH, 32'hFFFFFFFF, 32'h0000BEEF);
    repeat (5) @(posedge clk);
    #1;
    if (SPLIT) begin
      n_checks++;
      if (obs_q.size() != 4) begin
        n_fail++;
        $display("FAIL cross_count got %0d want 4", obs_q.size());
      end else begin
        n_checks++;
        if (obs_q[0] !== '{addr: 32'h400, wdata: 32'hCCDD0000, we: 4'b1100} ||
            obs_q[1] !== '{addr: 32'h404, wdata: 32'h0000AABB, we: 4'b0011}) begin
          n_fail++;
          $display("FAIL sw_split got %h/%h/%b %h/%h/%b want 400/ccdd0000/1100 404/0000aabb/0011",
                   obs_q[0].addr, obs_q[0].wdata, obs_q[0].we, obs_q[1].addr, obs_q[1].wdata, obs_q[1].we);
        end
        n_checks++;
        if (cyc_q[1] != cyc_q[0] + 1) begin
          n_fail++;
          $display("FAIL split_gap got %0d want %0d", cyc_q[1], cyc_q[0] + 1);
        end
        n_checks++;
        if (obs_q[2] !== '{addr: 32'hFFFFFFFC, wdata: 32'hEF000000, we: 4'b1000} ||
            obs_q[3] !== '{addr: 32'h0, wdata: 32'h000000BE, we: 4'b0001}) begin
          n_fail++;
          $display("FAIL wrap_split got %h/%h/%b %h/%h/%b want fffffffc/ef000000/1000 0/be/0001",
                   obs_q[2].addr, obs_q[2].wdata, obs_q[2].we, obs_q[3].addr, obs_q[3].wdata, obs_q[3].we);
        end
      end
    end else begin
      n_checks++;
      if (obs_q.size() != 0 || err_cnt != 2) begin
        n_fail++;
        $display("FAIL cross_drop got beats=%0d errs=%0d want 0/2", obs_q.size(), err_cnt);
      end
    end
  endtask

  task automatic test_rst_mid_split();
    clear_obs();
    mem_ready = 1'b0;
    send(FNC_SH, 32'hFFFFFFFF, 32'h00001234);
    @(negedge clk);
    n_checks++;
    if (SPLIT && {mem_valid, mem_addr, mem_we} !== {1'b1, 32'hFFFFFFFC, 4'b1000}) begin
      n_fail++;
      $display("FAIL pre_rst_beat got v=%b a=%h we=%b want 1/fffffffc/1000", mem_valid, mem_addr, mem_we);
    end else if (!SPLIT && mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_rst_nosplit got v=%b want 0", mem_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 ||
        {mem_valid, mem_addr, mem_wdata, mem_we, misalign_err, busy} !== 71'h0) begin
      n_fail++;
      $display("FAIL rst_mid_split got beats=%0d v=%b a=%h d=%h we=%b want 0 beats, outputs 0",
               obs_q.size(), mem_valid, mem_addr, mem_wdata, mem_we);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(FNC_SB, 32'h500 + 32'(i), 32'(8'h10 + i));
      model_store(FNC_SB, 32'h500 + 32'(i), 32'(8'h10 + i));
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL stream_count got %0d want 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || cyc_q[i] != cyc_q[0] + i) begin
          n_fail++;
          $display("FAIL stream_beat%0d got %h/%h/%b @%0d want %h/%h/%b @%0d", i,
                   obs_q[i].addr, obs_q[i].wdata, obs_q[i].we, cyc_q[i],
                   exp_q[i].addr, exp_q[i].wdata, exp_q[i].we, cyc_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_invalid_fnc();
    clear_obs();
    mem_ready = 1'b1;
    send(3'b111, 32'h600, 32'h12345678);
    @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b0 || misalign_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_fnc got v=%b err=%b busy=%b want 0/0/0", mem_valid, misalign_err, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL invalid_quiet got beats=%0d errs=%0d want 0/0", obs_q.size(), err_cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    clear_obs();
    rnd_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    f = FNC_SB;
        2, 3:    f = FNC_SH;
        4, 5, 6: f = FNC_SW;
        default: f = 3'b111;
      endcase
      a = $urandom;
      if (i % 5 == 0) a[31:2] = '1;
      d = $urandom;
      model_store(f, a, d);
      send(f, a, d);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    mem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != exp_q.size() || err_cnt != exp_err) begin
      n_fail++;
      $display("FAIL random_count got beats=%0d errs=%0d want %0d/%0d",
               obs_q.size(), err_cnt, exp_q.size(), exp_err);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_beat%0d got %h/%h/%b want %h/%h/%b", i,
                   obs_q[i].addr, obs_q[i].wdata, obs_q[i].we,
                   exp_q[i].addr, exp_q[i].wdata, exp_q[i].we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cross();
    test_rst_mid_split();
    test_back_to_back();
    test_invalid_fnc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
